uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares one UART serial transmit line among NUM_REQ byte producers, such as a command responder, debug logger or status reporter.
- Picks the next producer by round-robin, accepts its byte through a valid/ready handshake, and serialises it as 8N1 framing.
- Bit timing comes from the baud-rate generator's 1-cycle tx_enb tick (25 MHz / 217, 115200 baud).
- Sits between the producers and the tx pin, alongside the baud-rate generator.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, bits per frame payload.
- ID_W, $clog2(NUM_REQ), width of grant_id.

Ports:
- clk  input  1  system clock (25 MHz).
- rst  input  1  synchronous, active-high reset.
- tx_enb  input  1  one-cycle bit-period tick from the baud-rate generator.
- req_valid  input  NUM_REQ  per-requester byte-available flag.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot accept strobe; a byte transfers when valid[i] and ready[i] are both high.
- tx  output  1  serial line, idle high.
- busy  output  1  high whenever state is not IDLE.
- grant_id  output  ID_W  index of the most recently accepted requester.

Behaviour:
- Clock and reset: one clock. rst is synchronous and active-high. rst has priority over every other input, including a simultaneous tx_enb.
- Reset values: state=IDLE, tx=1, busy=0, req_ready=0, grant_id=0, RR pointer=0 (requester 0 highest priority), bit_cnt=0.
- States: IDLE, WAIT, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If any req_valid is set, the winner is the first set bit searching from ptr upward, wrapping modulo NUM_REQ.
  - req_ready[winner] is driven combinationally high in this same cycle and no other ready bit is high.
  - On that clock edge: shift_reg<=req_data[winner], grant_id<=winner, ptr<=(winner+1) mod NUM_REQ, state->WAIT.
  - tx_enb in IDLE is ignored.
- WAIT: on tx_enb, tx<=0 and state->START. This aligns the start bit to a tick boundary.
- START: on tx_enb, tx<=shift_reg[0], bit_cnt<=0, state->DATA.
- DATA:
  - On tx_enb with bit_cnt==DATA_W-1: tx<=1, state->STOP.
  - On any other tx_enb: shift right, tx<=next bit, bit_cnt++.
  - Bits go out LSB first.
- STOP: on tx_enb, state->IDLE. tx stays 1.
- Bit timing:
  - Every bit (start, data, stop) lasts exactly one tx_enb period.
  - A frame is DATA_W+2 periods, plus 0..1 period of WAIT alignment.
- Back-to-back frames: IDLE lasts one cycle when a valid is pending, so the next grant occurs the cycle after STOP ends.
- Without tx_enb: if tx_enb stays low, the FSM holds its state and tx holds its value indefinitely.
- Requester protocol: a requester must hold valid and data stable until it is accepted. Deasserting valid before ready is legal; that requester is simply not granted. No checking is done.
- req_ready is never high outside IDLE.
- Reset mid-frame: tx returns to 1 on the next cycle and the frame is discarded. The accepted byte is not re-requested, so it is lost; this is by design.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, WAIT, START, DATA, STOP}.
  - UART_DATA_W=8, UART_STOP_BITS=1.
  - TX_DIV=217, RX_DIV=14.
- Sub-module uart_rr_arbiter(NUM_REQ):
  - inputs: req, ptr, en.
  - outputs: one-hot grant, grant_idx, any.
  - combinational rotate / priority-encode / rotate back.
  - ptr register stays in the parent.

Test Plan:
- Reset: assert rst for 3 cycles with tx_enb and req_valid=4'b1111 active → tx=1, busy=0, req_ready=0, grant_id=0 throughout; first grant goes to requester 0 the cycle after rst falls.
- Single byte: req 0 sends 0xA5, tx_enb every 217 cycles → one-cycle req_ready=4'b0001; at successive ticks tx = 0,1,0,1,0,0,1,0,1,1; busy drops after the stop tick.
- All four requesters valid with data 0x10, 0x11, 0x12, 0x13 → grants in order 0,1,2,3; grant_id sequence 0,1,2,3; four frames decode to 0x10..0x13.
- Fairness: req1 and req3 continuously valid with ptr=0 → grants alternate 1,3,1,3; req0/req2 ready never asserted.
- Reset mid-frame: rst pulsed during DATA bit 4 → tx=1 the next cycle, busy=0, ptr=0; a still-pending req2 is re-granted and its full frame is sent.
- Tick corner cases:
  - tx_enb coincides with the IDLE grant cycle → ignored, and the start bit begins at the next tick.
  - tx_enb held low for 1000 cycles in WAIT → tx=1 and state unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and
// default framing / divider constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      START,
      DATA,
      STOP
   } tx_state_e;

   localparam int UART_DATA_W    = 8;
   localparam int UART_STOP_BITS = 1;
   localparam int TX_DIV         = 217;
   localparam int RX_DIV         = 14;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests to ptr,
// pick the lowest set bit, rotate the index back.
module uart_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any
);

   logic [NUM_REQ-1:0] rot;
   logic [ID_W-1:0]    off;
   logic [ID_W:0]      sum;

   assign rot = NUM_REQ'({req, req} >> ptr);

   always_comb begin
      off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = ID_W'(i);
      end
   end

   always_comb begin
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (ID_W + 1)'(NUM_REQ)) begin
         sum = sum - (ID_W + 1)'(NUM_REQ);
      end
   end

   assign grant_idx = sum[ID_W-1:0];
   assign any       = en & (|req);
   assign grant     = any ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler feeding one 8N1 UART tx line,
// bit timing driven by the baud generator's tx_enb tick.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = UART_DATA_W,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      tx_enb,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx,
   output logic                      busy,
   output logic [ID_W-1:0]           grant_id
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   tx_state_e          state;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    ptr_nxt;
   logic [CNT_W-1:0]   bit_cnt;
   logic [DATA_W-1:0]  shift_reg;
   logic [DATA_W-1:0]  win_data;
   logic [NUM_REQ-1:0] arb_grant;
   logic [ID_W-1:0]    win_idx;
   logic               arb_any;
   logic               arb_en;

   // Ready must stay low while reset is held, even once state is IDLE.
   assign arb_en = (state == IDLE) && !rst;

   uart_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .en        (arb_en),
      .grant     (arb_grant),
      .grant_idx (win_idx),
      .any       (arb_any)
   );

   assign req_ready = arb_grant;
   assign win_data  = req_data[win_idx*DATA_W +: DATA_W];
   assign ptr_nxt   = (win_idx == ID_W'(NUM_REQ - 1)) ?
                      '0 : win_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tx        <= 1'b1;
         busy      <= 1'b0;
         grant_id  <= '0;
         ptr       <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               tx <= 1'b1;
               if (arb_any) begin
                  shift_reg <= win_data;
                  grant_id  <= win_idx;
                  ptr       <= ptr_nxt;
                  busy      <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (tx_enb) begin
                  tx    <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (tx_enb) begin
                  tx      <= shift_reg[0];
                  bit_cnt <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (tx_enb) begin
                  if (bit_cnt == LAST) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shift_reg <= shift_reg >> 1;
                     tx        <= shift_reg[1];
                     bit_cnt   <= bit_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (tx_enb) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: tick-counting frame model,
// a line decoder, and directed scenarios.
module tb_uart_tx_scheduler;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int IW    = 2;
   localparam int FRAME = DW + 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          tx_enb;
   logic [N-1:0]  req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          tx;
   logic          busy;
   logic [IW-1:0] grant_id;

   uart_tx_scheduler #(
      .NUM_REQ (N),
      .DATA_W  (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_enb    (tx_enb),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx        (tx),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always #5 clk = ~clk;

   int n_pass;
   int n_tot;

   logic          m_busy;
   int            m_ticks;
   logic [DW-1:0] m_data;
   int            m_ptr;
   int            m_gid;
   logic          chk_en;

   logic [N-1:0]  acc;
   logic [N-1:0]  hold;
   logic [N-1:0]  ready_or;
   logic          last_tick;
   logic          prev_acc;
   logic          tick_log[$];
   int            id_log[$];
   logic [DW-1:0] rx_q[$];
   logic          rx_act;
   int            rx_cnt;
   logic [DW-1:0] rx_sh;

   logic          tick_auto;
   logic          tick_man;
   int            div;
   int            tcnt;

   logic [9:0]    a5_bits;
   int            stuck;
   int            exp_id[4];

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, got, exp);
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic exp_tx();
      if (!m_busy || m_ticks == 0 || m_ticks >= DW + 2) return 1'b1;
      if (m_ticks == 1) return 1'b0;
      return m_data[m_ticks-2];
   endfunction

   task automatic rx_feed(input logic s);
      if (!rx_act) begin
         if (s == 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
         end
      end else if (rx_cnt < DW) begin
         rx_sh[rx_cnt] = s;
         rx_cnt++;
      end else begin
         chk("stop_bit", s, 1);
         rx_q.push_back(rx_sh);
         rx_act = 1'b0;
      end
   endtask

   // Per-cycle compare against the model, then advance the model
   // to what the coming clock edge must produce.
   task automatic observe();
      int w;
      logic [N-1:0] e_ready;
      logic s;
      w = rr_pick(req_valid, m_ptr);
      if (chk_en) begin
         if (last_tick) begin
            s = tx;
            tick_log.push_back(s);
            rx_feed(s);
         end
         if (prev_acc) id_log.push_back(int'(grant_id));
         e_ready = (!rst && !m_busy && w >= 0) ? (N'(1) << w) : '0;
         chk("req_ready", req_ready, e_ready);
         chk("tx", tx, exp_tx());
         chk("busy", busy, m_busy);
         chk("grant_id", grant_id, m_gid);
         ready_or = ready_or | req_ready;
      end
      acc = req_valid & req_ready;
      if (acc != '0) tick_log.delete();
      prev_acc  = (acc != '0) && !rst;
      last_tick = tx_enb && busy && !rst;
      if (rst) begin
         m_busy  = 1'b0;
         m_ticks = 0;
         m_ptr   = 0;
         m_gid   = 0;
         rx_act  = 1'b0;
         chk_en  = 1'b1;
      end else if (!m_busy) begin
         if (w >= 0) begin
            m_busy  = 1'b1;
            m_ticks = 0;
            m_data  = req_data[w*DW +: DW];
            m_gid   = w;
            m_ptr   = (w + 1) % N;
         end
      end else if (tx_enb) begin
         m_ticks++;
         if (m_ticks == FRAME) begin
            m_busy  = 1'b0;
            m_ticks = 0;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~(acc & ~hold);
      if (tick_auto) begin
         if (tcnt >= div - 1) begin
            tx_enb = 1'b1;
            tcnt   = 0;
         end else begin
            tx_enb = 1'b0;
            tcnt++;
         end
      end else begin
         tx_enb = tick_man;
      end
   endtask

   function automatic int id_at(input int i);
      return (i < id_log.size()) ? id_log[i] : -1;
   endfunction

   function automatic int rx_at(input int i);
      return (i < rx_q.size()) ? int'(rx_q[i]) : -1;
   endfunction

   task automatic clear_logs();
      tick_log.delete();
      id_log.delete();
      rx_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_pass = 0;  n_tot = 0;
      m_busy = 0;  m_ticks = 0;  m_data = '0;
      m_ptr = 0;   m_gid = 0;    chk_en = 0;
      acc = '0;    hold = '0;    ready_or = '0;
      last_tick = 0;  prev_acc = 0;
      rx_act = 0;  rx_cnt = 0;   rx_sh = '0;
      tick_auto = 1;  tick_man = 0;  div = 1;  tcnt = 0;
      a5_bits = 10'b1101001010;
      stuck = 0;

      // Reset held with every request and the tick active.
      rst       = 1'b1;
      tx_enb    = 1'b0;
      req_valid = 4'hF;
      req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      repeat (3) begin
         step();
         #1;
         chk("rst_tx", tx, 1);
         chk("rst_busy", busy, 0);
         chk("rst_ready", req_ready, 0);
         chk("rst_gid", grant_id, 0);
      end
      rst = 1'b0;
      #1;
      chk("first_grant", req_ready, 4'b0001);
      for (int c = 0; c < 400 && !(rx_q.size() >= 4 && !busy); c++) step();
      chk("t1_done", rx_q.size() >= 4 && !busy, 1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_id%0d", i), id_at(i), i);
         chk($sformatf("t1_byte%0d", i), rx_at(i), 8'h10 + i);
      end

      // Single byte 0xA5 at the real baud divider.
      clear_logs();
      div  = 217;
      tcnt = 0;
      req_data[7:0] = 8'hA5;
      req_valid = 4'b0001;
      #1;
      chk("a5_ready", req_ready, 4'b0001);
      for (int c = 0; c < 4000 && tick_log.size() < 10; c++) step();
      chk("a5_busy_stop", busy, 1);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("a5_bit%0d", i),
             (i < tick_log.size()) ? tick_log[i] : 1'bx, a5_bits[i]);
      end
      for (int c = 0; c < 400 && tick_log.size() < 11; c++) step();
      chk("a5_busy_after", busy, 0);

      // Fairness: requesters 1 and 3 always valid, ptr reset to 0.
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_logs();
      ready_or  = '0;
      div       = 3;
      tcnt      = 0;
      hold      = 4'b1010;
      req_valid = 4'b1010;
      for (int c = 0; c < 600 && id_log.size() < 4; c++) step();
      req_valid = '0;
      hold      = '0;
      for (int c = 0; c < 200 && busy; c++) step();
      chk("fair_idle", busy, 0);
      exp_id = '{1, 3, 1, 3};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fair_id%0d", i), id_at(i), exp_id[i]);
      end
      chk("fair_ready_or", ready_or, 4'b1010);

      // Reset during data bit 4; pending requests resume from ptr 0.
      clear_logs();
      req_data  = {8'h3C, 8'h5C, 8'h00, 8'h00};
      hold      = 4'b0100;
      req_valid = 4'b0100;
      for (int c = 0; c < 200 && !(id_log.size() >= 1 && tick_log.size() >= 6);
           c++) step();
      chk("mid_bit4", tx, 1);
      rst       = 1'b1;
      hold      = '0;
      req_valid = 4'b1100;
      step();
      rst = 1'b0;
      chk("mid_tx", tx, 1);
      chk("mid_busy", busy, 0);
      #1;
      chk("mid_ptr0", req_ready, 4'b0100);
      id_log.delete();
      rx_q.delete();
      for (int c = 0; c < 300 && !(rx_q.size() >= 2 && !busy); c++) step();
      chk("mid_id0", id_at(0), 2);
      chk("mid_id1", id_at(1), 3);
      chk("mid_byte0", rx_at(0), 8'h5C);
      chk("mid_byte1", rx_at(1), 8'h3C);

      // Tick on the grant cycle, then a long stall in WAIT.
      clear_logs();
      tick_auto = 1'b0;
      tick_man  = 1'b0;
      req_data[7:0] = 8'h81;
      req_valid = 4'b0001;
      tx_enb    = 1'b1;
      step();
      chk("grant_tick_busy", busy, 1);
      chk("grant_tick_tx", tx, 1);
      repeat (1000) begin
         step();
         if (tx !== 1'b1 || busy !== 1'b1) stuck++;
      end
      chk("wait_hold", stuck, 0);
      tick_man = 1'b1;
      step();
      tick_man = 1'b0;
      step();
      chk("start_after_tick", tx, 0);
      tick_auto = 1'b1;
      div  = 4;
      tcnt = 0;
      for (int c = 0; c < 200 && !(rx_q.size() >= 1 && !busy); c++) step();
      chk("t6_byte", rx_at(0), 8'h81);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
